pulse_stretcher: RTL
====================

# pulse_stretcher

- Turns single-cycle event pulses back into human-visible levels, e.g. trigger-fired or button-pulse strobes driving an LED or a mode flag.
- Produces a high output of fixed length, followed by a guaranteed low gap, so that every event is visible.
- One event arriving during the gap is queued. Any event that cannot be shown is counted.
- Sits between pulse-producing control logic and front-panel indicators.

## Interface
- HOLD_CYCLES, 1_000_000: cycles level_out stays high per event; must be ≥1
- GAP_CYCLES, 100_000: minimum low cycles between two highs; must be ≥1
- MISS_W, 8: width of the saturating miss counter
- clock  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- pulse_in  in  1  event strobe; every cycle sampled high is one event
- miss_clr  in  1  synchronous clear of miss_count
- level_out  out  1  stretched output
- busy  out  1  high in HOLD or GAP
- pending  out  1  one event queued during GAP
- miss_count  out  MISS_W  saturating count of dropped events

## Operation
- The FSM has three states: IDLE, HOLD and GAP. All outputs are registered.
- A single down-counter, CNT_W = clog2(max(HOLD_CYCLES, GAP_CYCLES)) bits wide, is used in both HOLD and GAP.
- IDLE:
  - pulse_in=1 → HOLD, counter loaded with HOLD_CYCLES-1, level_out=1.
- HOLD:
  - Counter decrements each cycle.
  - At 0 → GAP, counter loaded with GAP_CYCLES-1, level_out=0.
  - An event in HOLD is handled according to the Configuration section, including on the last HOLD cycle.
- GAP:
  - An event with pending=0 sets pending.
  - An event with pending=1 increments miss_count.
  - At count 0:
    - if pending=1 or pulse_in=1 → HOLD; pending cleared, level_out=1
    - otherwise → IDLE
  - In the pulse_in=1 case, the last-cycle event is consumed directly and is not counted as a miss.
- miss_count saturates at 2^MISS_W-1.
- miss_clr has priority over an increment in the same cycle; the result is 0.
- busy = (state != IDLE).

## Timing
- Reset (asynchronous assert): state IDLE, level_out=0, busy=0, pending=0, miss_count=0, counter=0.
- Reset release: the first event can be accepted at the first rising edge after reset_n is high.
- Latency: pulse_in sampled at edge E0 → level_out high from E0 through edge E0+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles.
- level_out is low for at least GAP_CYCLES cycles between two high periods.
- A queued event produces a low gap of exactly GAP_CYCLES cycles.
- Reset asserted during any state:
  - aborts immediately
  - any queued event is discarded
  - level_out drops without waiting for the clock

## Configuration
- PULSE_STRETCHER_RETRIGGER_EN defined:
  - An event in HOLD reloads the counter to HOLD_CYCLES-1, extending the high period.
  - It is not counted as a miss.
- Macro undefined:
  - An event in HOLD is dropped and increments miss_count.
  - The high period stays exactly HOLD_CYCLES.
- GAP and pending behaviour are identical in both builds.

## Structure
- Shared package pulse_stretcher_pkg contains:
  - state enum (IDLE, HOLD, GAP)
  - counter-width helper function
- Sub-module sat_counter: MISS_W-bit saturating incrementer with synchronous clear priority; it implements miss_count.
- FSM and down-counter live in the top module.

## Test plan
All scenarios use HOLD_CYCLES=4, GAP_CYCLES=2, MISS_W=2.
1. Single pulse → level_out high 4 cycles, low after; busy high 6 cycles; miss_count=0.
2. Second pulse on cycle 2 of HOLD:
   - Macro off → level_out high 4 cycles, miss_count=1.
   - Macro on → level_out high 6 cycles, miss_count=0.
3. Pulse in GAP cycle 1 → pending=1; level_out low exactly 2 cycles, then high 4 cycles; pending clears on HOLD entry.
4. Two pulses in one GAP → pending=1, miss_count=1; second HOLD follows. A pulse on the last GAP cycle with pending=0 → HOLD, no miss.
5. Five dropped events (macro off) → miss_count saturates at 3. miss_clr asserted in the same cycle as a miss → 0.
6. reset_n low mid-HOLD with pending=1 → level_out, busy, pending and miss_count all 0 asynchronously. A pulse after release → normal 4-cycle high.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// the width of the shared HOLD/GAP down-counter.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Bits needed to hold max(hold, gap) - 1, never less than one bit so the
  // counter stays a real vector for the degenerate 1/1 configuration.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int longest;
    int w;
    longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    w       = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event/indicator bundle between pulse-producing control logic (master) and
// the pulse stretcher (slave).
interface pulse_stretcher_if #(
  parameter int MISS_W = 8
);
  logic              pulse_in;
  logic              miss_clr;
  logic              level_out;
  logic              busy;
  logic              pending;
  logic [MISS_W-1:0] miss_count;

  modport master (
    output pulse_in,
    output miss_clr,
    input  level_out,
    input  busy,
    input  pending,
    input  miss_count
  );

  modport slave (
    input  pulse_in,
    input  miss_clr,
    output level_out,
    output busy,
    output pending,
    output miss_count
  );
endinterface

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up-counter used for the dropped-event tally. A clear in the same
// cycle as an increment wins, so software never sees a stale count after clr.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_count;

  // Count register: clear beats increment, increment stops at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle events into a HOLD_CYCLES-long high
// level followed by a guaranteed GAP_CYCLES-long low gap. One event arriving
// during the gap is queued; events that can never be shown are counted.
// Optional build macro: PULSE_STRETCHER_RETRIGGER_EN -- when defined, an event
// during the high period restarts it instead of being dropped.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_000_000,
  parameter int GAP_CYCLES  = 100_000,
  parameter int MISS_W      = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  pulse_stretcher_if.slave  bus
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_level;
  logic               r_busy;
  logic               r_pending;

  state_t             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_level_next;
  logic               w_busy_next;
  logic               w_pending_next;
  logic               w_miss_inc;
  logic [MISS_W-1:0]  w_miss_count;
  logic               w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Next-state, counter and registered-output decode for IDLE/HOLD/GAP.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pending_next = r_pending;
    w_miss_inc     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.pulse_in) begin
          w_state_next = HOLD;
          w_cnt_next   = HOLD_LOAD;
        end
      end

      HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (bus.pulse_in) begin
          w_cnt_next = HOLD_LOAD;
        end else if (w_cnt_zero) begin
          w_state_next = GAP;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
`else
        // The high period is fixed; anything arriving now is lost.
        w_miss_inc = bus.pulse_in;
        if (w_cnt_zero) begin
          w_state_next = GAP;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
`endif
      end

      GAP: begin
        if (w_cnt_zero) begin
          if (r_pending || bus.pulse_in) begin
            // The queued event (or a fresh one) starts the next high period;
            // a fresh event on top of a queued one has nowhere to go.
            w_state_next   = HOLD;
            w_cnt_next     = HOLD_LOAD;
            w_pending_next = 1'b0;
            w_miss_inc     = r_pending && bus.pulse_in;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
          if (bus.pulse_in) begin
            if (r_pending) begin
              w_miss_inc = 1'b1;
            end else begin
              w_pending_next = 1'b1;
            end
          end
        end
      end

      default: begin
        w_state_next   = IDLE;
        w_cnt_next     = '0;
        w_pending_next = 1'b0;
      end
    endcase

    w_level_next = (w_state_next == HOLD);
    w_busy_next  = (w_state_next != IDLE);
  end

  // State, counter and output registers; reset drops the level immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_busy    <= w_busy_next;
      r_pending <= w_pending_next;
    end
  end

  sat_counter #(
    .W (MISS_W)
  ) u_miss (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_miss_inc),
    .i_clr   (bus.miss_clr),
    .o_count (w_miss_count)
  );

  assign bus.level_out  = r_level;
  assign bus.busy       = r_busy;
  assign bus.pending    = r_pending;
  assign bus.miss_count = w_miss_count;

endmodule
